mem_clk_sequencer: RTL and testbench

Bring-up and supervision controller for the DRAM clock rPLL, running in the always-present 27 MHz reference domain. It pulses the PLL reset, qualifies lock with a timeout and a stability window, and retries a bounded number of times. It releases the memory-domain reset only after a stable lock and owns the PLL's dynamic phase (PSDA) setting. Phase steps use a request/acknowledge handshake, and the memory domain is held in reset across each step.

---
 rtl/mem_clk_pkg.sv | 21 ++
 rtl/mem_sync2.sv | 22 ++
 rtl/mem_clk_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mem_clk_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_clk_pkg.sv
// Shared types and widths for the DRAM clock rPLL bring-up sequencer.
package mem_clk_pkg;

  localparam int PSDA_W  = 4;
  localparam int RETRY_W = 3;

  typedef enum logic [2:0] {
    PLL_RST      = 3'd0,
    WAIT_LOCK    = 3'd1,
    STABLE       = 3'd2,
    RUN          = 3'd3,
    PHASE_HOLD   = 3'd4,
    PHASE_SETTLE = 3'd5,
    FAIL         = 3'd6
  } mem_clk_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Latency: 2 clk edges; no flow control.
module mem_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_clk_sequencer.sv
// rPLL bring-up/supervision FSM: reset pulse, lock timeout with bounded retries, stability window, memory reset release.
// All outputs registered from the next state; phase stepping (req/ack, no backpressure) exists only with MEM_CLK_PHASE_CTRL_EN.
module mem_clk_sequencer
  import mem_clk_pkg::*;
#(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 65535,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         MAX_RETRIES   = 7,
  parameter int         SETTLE_CYCLES = 64,
  parameter logic [3:0] PSDA_INIT     = 4'b0000
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] pll_psda,
  output logic       mem_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt,
  input  logic       phase_req,
  input  logic [3:0] phase_val,
  output logic       phase_ack
);

  localparam int CNT_MAX = max_of(max_of(1, RST_CYCLES), max_of(max_of(LOCK_TIMEOUT, STABLE_CYCLES), SETTLE_CYCLES));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  // The cycle that moved us into STABLE already saw lock_s high, so it counts toward the window.
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  mem_clk_state_t     state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               lock_s;

`ifdef MEM_CLK_PHASE_CTRL_EN
  localparam logic [CNT_W-1:0] SETTLE_ACK = CNT_W'(SETTLE_CYCLES);
  logic [PSDA_W-1:0] cap_q, cap_nxt, psda_q, psda_nxt;
  logic              ack_q, ack_nxt;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  mem_sync2 u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = sat_inc(cnt);
    retry_nxt = retry_cnt;
`ifdef MEM_CLK_PHASE_CTRL_EN
    cap_nxt   = cap_q;
    psda_nxt  = psda_q;
    ack_nxt   = 1'b0;
`endif
    case (state)
      PLL_RST: begin
        if (cnt >= RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt >= LOCK_LAST) begin
          if (retry_cnt >= RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            retry_nxt = retry_cnt + 1'b1;
            state_nxt = PLL_RST;
          end
        end
      end
      STABLE: begin
        if (!lock_s) state_nxt = WAIT_LOCK;
        else if (cnt >= STABLE_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = PLL_RST;
`ifdef MEM_CLK_PHASE_CTRL_EN
        end else if (phase_req) begin
          cap_nxt   = phase_val;
          state_nxt = PHASE_HOLD;
`endif
        end
      end
`ifdef MEM_CLK_PHASE_CTRL_EN
      PHASE_HOLD: begin
        psda_nxt  = cap_q;
        state_nxt = PHASE_SETTLE;
      end
      PHASE_SETTLE: begin
        // The ack cycle is still spent here so mem_rst_n rises one cycle after the pulse.
        if (!lock_s) state_nxt = PLL_RST;
        else if (ack_q) state_nxt = RUN;
        else if (cnt == SETTLE_ACK) ack_nxt = 1'b1;
      end
`endif
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = PLL_RST;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
    if (state_nxt == RUN && state != RUN) retry_nxt = '0;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLL_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      mem_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
`ifdef MEM_CLK_PHASE_CTRL_EN
      cap_q     <= PSDA_INIT;
      psda_q    <= PSDA_INIT;
      ack_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_reset <= (state_nxt == PLL_RST) || (state_nxt == FAIL);
      mem_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
`ifdef MEM_CLK_PHASE_CTRL_EN
      cap_q     <= cap_nxt;
      psda_q    <= psda_nxt;
      ack_q     <= ack_nxt;
`endif
    end
  end

`ifdef MEM_CLK_PHASE_CTRL_EN
  assign pll_psda  = psda_q;
  assign phase_ack = ack_q;
`else
  logic unused_phase;
  assign unused_phase = ^{phase_req, phase_val};
  assign pll_psda     = PSDA_INIT;
  assign phase_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_clk_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed output-change events, a negedge monitor pops and compares them.
module tb_mem_clk_sequencer;

  localparam int PI = 3;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       phase_req = 1'b0;
  logic [3:0] phase_val = 4'h0;
  logic       pll_reset, mem_rst_n, ready, fail, phase_ack;
  logic [3:0] pll_psda;
  logic [2:0] retry_cnt;

  mem_clk_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SETTLE_CYCLES (6),
    .PSDA_INIT     (4'b0011)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_psda  (pll_psda),
    .mem_rst_n (mem_rst_n),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .phase_req (phase_req),
    .phase_val (phase_val),
    .phase_ack (phase_ack)
  );

  always #5 clkin = ~clkin;

  // Edge index since reset release: edge 1 is the first posedge with rst_n high.
  int cyc = 0;
  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string       name;
    int          cyc;
    logic [11:0] vec;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          snap_req = 0, snap_ack = 0;
  int          flush_req = 0, flush_ack = 0;
  bit          mon_en = 1'b0;
  string       scen = "none";
  logic [11:0] prev;

  // Packing: {pll_reset, mem_rst_n, ready, fail, retry_cnt, phase_ack, pll_psda}
  function automatic logic [11:0] mk(input int pr, input int mr, input int rd, input int fl,
                                     input int rc, input int ak, input int ps);
    return {pr[0], mr[0], rd[0], fl[0], rc[2:0], ak[0], ps[3:0]};
  endfunction

  task automatic expect_ev(input string nm, input int c, input logic [11:0] v);
    exp_t e;
    e.name = nm;
    e.cyc  = c;
    e.vec  = v;
    q.push_back(e);
  endtask

  always @(negedge clkin) begin
    logic [11:0] cur;
    exp_t        e;
    cur = {pll_reset, mem_rst_n, ready, fail, retry_cnt, phase_ack, pll_psda};
    if (snap_req != snap_ack || (mon_en && cur !== prev)) begin
      snap_ack = snap_req;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL %s_unexpected: cyc=%0d out=%h, no event expected", scen, cyc, cur);
      end else begin
        e = q.pop_front();
        if (cur !== e.vec || cyc != e.cyc) begin
          failures++;
          $display("FAIL %s: got cyc=%0d out=%h, want cyc=%0d out=%h", e.name, cyc, cur, e.cyc, e.vec);
        end
      end
    end
    if (flush_req != flush_ack) begin
      flush_ack = flush_req;
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL %s_missing: %0d events never seen, first %s want cyc=%0d out=%h",
                 scen, q.size(), q[0].name, q[0].cyc, q[0].vec);
        q.delete();
      end
    end
    prev = cur;
  end

  task automatic to_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 2000) begin
      @(posedge clkin);
      #1;
      guard++;
    end
  endtask

  task automatic do_reset(input string nm);
    @(posedge clkin);
    #1;
    mon_en    = 1'b0;
    scen      = nm;
    rst_n     = 1'b0;
    pll_lock  = 1'b0;
    phase_req = 1'b0;
    phase_val = 4'h0;
    expect_ev({nm, "_reset"}, 0, mk(1, 0, 0, 0, 0, 0, PI));
    snap_req++;
    repeat (2) @(posedge clkin);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic end_scen(input int n);
    to_cyc(n);
    flush_req++;
  endtask

  initial begin
    // 1: nominal bring-up, lock 5 cycles after pll_reset falls -> RUN at 4+5+2+8
    do_reset("s1");
    expect_ev("s1_rst_fall", 4, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s1_run", 19, mk(0, 1, 1, 0, 0, 0, PI));
    to_cyc(9);  pll_lock = 1'b1;
    end_scen(30);

    // 2: no lock, two retries then sticky FAIL
    do_reset("s2");
    expect_ev("s2_rst_fall0", 4,  mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s2_retry1",    24, mk(1, 0, 0, 0, 1, 0, PI));
    expect_ev("s2_rst_fall1", 28, mk(0, 0, 0, 0, 1, 0, PI));
    expect_ev("s2_retry2",    48, mk(1, 0, 0, 0, 2, 0, PI));
    expect_ev("s2_rst_fall2", 52, mk(0, 0, 0, 0, 2, 0, PI));
    expect_ev("s2_fail",      72, mk(1, 0, 0, 1, 2, 0, PI));
    to_cyc(80); pll_lock = 1'b1;
    end_scen(100);

    // 3: one-cycle glitch during STABLE restarts the window
    do_reset("s3");
    expect_ev("s3_rst_fall", 4, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s3_run", 25, mk(0, 1, 1, 0, 0, 0, PI));
    to_cyc(9);  pll_lock = 1'b1;
    to_cyc(14); pll_lock = 1'b0;
    to_cyc(15); pll_lock = 1'b1;
    end_scen(35);

    // 4: early request ignored, then phase step to 0101 in RUN
    do_reset("s4");
    expect_ev("s4_rst_fall", 4, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s4_run", 19, mk(0, 1, 1, 0, 0, 0, PI));
`ifdef MEM_CLK_PHASE_CTRL_EN
    expect_ev("s4_hold",   23, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s4_psda",   24, mk(0, 0, 0, 0, 0, 0, 5));
    expect_ev("s4_ack",    31, mk(0, 0, 0, 0, 0, 1, 5));
    expect_ev("s4_rerun",  32, mk(0, 1, 1, 0, 0, 0, 5));
`endif
    to_cyc(9);  pll_lock = 1'b1;
    to_cyc(10); phase_req = 1'b1; phase_val = 4'h9;
    to_cyc(11); phase_req = 1'b0; phase_val = 4'h0;
    to_cyc(22); phase_req = 1'b1; phase_val = 4'h5;
    to_cyc(23); phase_req = 1'b0; phase_val = 4'hA;
    end_scen(45);

    // 5: lock lost during settle -> no ack, PLL reset pulse, re-lock
    do_reset("s5");
    expect_ev("s5_rst_fall", 4, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s5_run", 19, mk(0, 1, 1, 0, 0, 0, PI));
`ifdef MEM_CLK_PHASE_CTRL_EN
    expect_ev("s5_hold",     23, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s5_psda",     24, mk(0, 0, 0, 0, 0, 0, 5));
    expect_ev("s5_pll_rst",  29, mk(1, 0, 0, 0, 0, 0, 5));
    expect_ev("s5_rst_fall2", 33, mk(0, 0, 0, 0, 0, 0, 5));
    expect_ev("s5_rerun",    45, mk(0, 1, 1, 0, 0, 0, 5));
`else
    expect_ev("s5_pll_rst",  29, mk(1, 0, 0, 0, 0, 0, PI));
    expect_ev("s5_rst_fall2", 33, mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s5_rerun",    45, mk(0, 1, 1, 0, 0, 0, PI));
`endif
    to_cyc(9);  pll_lock = 1'b1;
    to_cyc(22); phase_req = 1'b1; phase_val = 4'h5;
    to_cyc(23); phase_req = 1'b0; phase_val = 4'h0;
    to_cyc(26); pll_lock = 1'b0;
    to_cyc(35); pll_lock = 1'b1;
    end_scen(55);

    // 6: request coincides with lock loss in RUN -> PLL_RST, psda untouched
    do_reset("s6");
    expect_ev("s6_rst_fall", 4,  mk(0, 0, 0, 0, 0, 0, PI));
    expect_ev("s6_run",      19, mk(0, 1, 1, 0, 0, 0, PI));
    expect_ev("s6_pll_rst",  23, mk(1, 0, 0, 0, 0, 0, PI));
    expect_ev("s6_rst_fall2", 27, mk(0, 0, 0, 0, 0, 0, PI));
    to_cyc(9);  pll_lock = 1'b1;
    to_cyc(20); pll_lock = 1'b0;
    to_cyc(22); phase_req = 1'b1; phase_val = 4'h5;
    to_cyc(23); phase_req = 1'b0; phase_val = 4'h0;
    end_scen(40);

    repeat (3) @(negedge clkin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
